// File: rtl/arm_mem_pkg.sv
// Shared types and helpers for the data-memory stage.
// Covers the FSM state encoding, byte-lane constants, the wait counter
// width and the byte-lane write-enable decode.
package arm_mem_pkg;

    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } mem_state_t;

    localparam logic [1:0] LANE_0 = 2'd0;
    localparam logic [1:0] LANE_1 = 2'd1;
    localparam logic [1:0] LANE_2 = 2'd2;
    localparam logic [1:0] LANE_3 = 2'd3;

    // Word accesses enable every lane; byte accesses enable only the addressed lane.
    function automatic logic [3:0] lane_we(input logic byte_acc, input logic [1:0] lane);
        logic [3:0] we;
        if (!byte_acc) begin
            we = 4'b1111;
        end else begin
            case (lane)
                LANE_0:  we = 4'b0001;
                LANE_1:  we = 4'b0010;
                LANE_2:  we = 4'b0100;
                default: we = 4'b1000;
            endcase
        end
        return we;
    endfunction

endpackage

// File: rtl/dmem_ram.sv
// Single-port synchronous RAM with DEPTH x 32 bits and per-byte-lane write enables.
// A read is any enabled access with no lane write. Read data is registered,
// and it holds between reads.
module dmem_ram #(
    parameter int DEPTH  = 1024,
    parameter int ADDR_W = 10
) (
    input  logic              clk_i,
    input  logic              en_i,
    input  logic [3:0]        we_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [31:0]       wdata_i,
    output logic [31:0]       rdata_o
);

    logic [31:0] mem [DEPTH];
    logic [31:0] rdata_q;

    // Lane-masked write or registered read.
    always_ff @(posedge clk_i) begin
        if (en_i) begin
            for (int b = 0; b < 4; b++) begin
                if (we_i[b]) begin
                    mem[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
                end
            end
            if (we_i == 4'b0000) begin
                rdata_q <= mem[addr_i];
            end
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/mux2.sv
// Generic 2:1 mux. sel_i=0 selects a_i and sel_i=1 selects b_i.
module mux2 #(
    parameter int W = 32
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  logic         sel_i,
    output logic [W-1:0] y_o
);

    assign y_o = sel_i ? b_i : a_i;

endmodule

// File: rtl/data_mem_stage.sv
// Data-memory stage for the ARM single-cycle datapath.
// It handles LDR, STR, LDRB and STRB against a multi-cycle RAM.
// Stall freezes the PC and writeback until a load commits.
// Optional feature: define ALIGN_CHECK_EN to flag misaligned word accesses
// on Fault. When this is enabled, misaligned stores are dropped and
// misaligned loads return 0.
//
//  state   | meaning
//  --------+----------------------------------------------------------
//  ST_IDLE | accept a load (issue RAM read) or a store (write now)
//  ST_WAIT | extra load wait states; inputs ignored, datapath frozen
//  ST_RESP | load data presented on ReadData; datapath commits
module data_mem_stage
    import arm_mem_pkg::*;
#(
    parameter int DEPTH       = 1024,
    parameter int ADDR_W      = $clog2(DEPTH),
    parameter int WAIT_CYCLES = 2
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic        ByteAcc,
    input  logic [31:0] Addr,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output logic        Stall,
    output logic        Fault
);

`ifdef ALIGN_CHECK_EN
    localparam bit ALIGN_EN = 1'b1;
`else
    localparam bit ALIGN_EN = 1'b0;
`endif

    // The counter reaches zero on the last wait-state cycle, so ST_WAIT lasts WAIT_CYCLES cycles.
    localparam logic [CNT_W-1:0] CNT_INIT =
        (WAIT_CYCLES > 0) ? CNT_W'(WAIT_CYCLES - 1) : '0;

    mem_state_t        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              byte_q, byte_d;
    logic [1:0]        lane_q, lane_d;
    logic              mis_q, mis_d;

    logic              ram_en, ram_en_raw;
    logic [3:0]        ram_we, ram_we_raw;
    logic [31:0]       ram_wdata;
    logic [31:0]       ram_rdata;
    logic [31:0]       byte_ext;
    logic [31:0]       mux_data;
    logic [31:0]       load_data;
    logic              misaligned;
    logic              stall_raw;
    logic              fault_raw;
    logic              unused_addr_hi;

    assign unused_addr_hi = ^Addr[31:ADDR_W+2];
    assign misaligned     = !ByteAcc && (Addr[1:0] != 2'b00);
    assign ram_wdata      = ByteAcc ? {4{WriteData[7:0]}} : WriteData;

    dmem_ram #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk_i   (Clk),
        .en_i    (ram_en),
        .we_i    (ram_we),
        .addr_i  (Addr[ADDR_W+1:2]),
        .wdata_i (ram_wdata),
        .rdata_o (ram_rdata)
    );

    // Extract the byte lane captured when the load was issued, then zero-extend it.
    assign byte_ext = {24'b0, ram_rdata[{lane_q, 3'b000} +: 8]};

    mux2 #(.W(32)) u_rd_mux (
        .a_i   (ram_rdata),
        .b_i   (byte_ext),
        .sel_i (byte_q),
        .y_o   (mux_data)
    );

    assign load_data = mis_q ? 32'b0 : mux_data;

    // Next-state, RAM control and raw stall/fault decode.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rdata_d    = rdata_q;
        byte_d     = byte_q;
        lane_d     = lane_q;
        mis_d      = mis_q;
        ram_en_raw = 1'b0;
        ram_we_raw = 4'b0000;
        stall_raw  = 1'b0;
        fault_raw  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (MemRead) begin
                    stall_raw  = 1'b1;
                    ram_en_raw = 1'b1;
                    byte_d     = ByteAcc;
                    lane_d     = Addr[1:0];
                    mis_d      = ALIGN_EN && misaligned;
                    if (WAIT_CYCLES == 0) begin
                        state_d = ST_RESP;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = CNT_INIT;
                    end
                end else if (MemWrite) begin
                    fault_raw = ALIGN_EN && misaligned;
                    if (!fault_raw) begin
                        ram_en_raw = 1'b1;
                        ram_we_raw = lane_we(ByteAcc, Addr[1:0]);
                    end
                end
            end
            ST_WAIT: begin
                stall_raw = 1'b1;
                if (cnt_q == '0) begin
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_RESP: begin
                fault_raw = mis_q;
                rdata_d   = load_data;
                state_d   = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Reset blocks RAM access as well as stall and fault.
    assign ram_en   = Rst && ram_en_raw;
    assign ram_we   = Rst ? ram_we_raw : 4'b0000;
    assign Stall    = Rst && stall_raw;
    assign Fault    = Rst && fault_raw;
    assign ReadData = (state_q == ST_RESP) ? load_data : rdata_q;

    // State registers with synchronous active-low reset.
    always_ff @(posedge Clk) begin
        if (!Rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            rdata_q <= '0;
            byte_q  <= 1'b0;
            lane_q  <= LANE_0;
            mis_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            byte_q  <= byte_d;
            lane_q  <= lane_d;
            mis_q   <= mis_d;
        end
    end

endmodule

// File: tb/tb_data_mem_stage.sv
// Self-checking bench for data_mem_stage.
// It uses a table of directed vectors, hand-written reset sequences, and
// randomized traffic that is checked against a word-array memory model.
module tb_data_mem_stage;

    localparam int DEPTH = 1024;
    localparam int W     = 2;
`ifdef ALIGN_CHECK_EN
    localparam bit ALIGN = 1'b1;
`else
    localparam bit ALIGN = 1'b0;
`endif

    logic        Clk = 1'b0;
    logic        Rst;
    logic        MemRead;
    logic        MemWrite;
    logic        ByteAcc;
    logic [31:0] Addr;
    logic [31:0] WriteData;
    logic [31:0] ReadData;
    logic        Stall;
    logic        Fault;

    int checks = 0;
    int errors = 0;

    logic [31:0] model [DEPTH];

    typedef struct {
        bit          is_load;
        bit          b;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_data;
        bit          exp_fault;
    } vec_t;

    vec_t vecs[$];

    data_mem_stage #(
        .DEPTH       (DEPTH),
        .ADDR_W      (10),
        .WAIT_CYCLES (W)
    ) dut (
        .Clk       (Clk),
        .Rst       (Rst),
        .MemRead   (MemRead),
        .MemWrite  (MemWrite),
        .ByteAcc   (ByteAcc),
        .Addr      (Addr),
        .WriteData (WriteData),
        .ReadData  (ReadData),
        .Stall     (Stall),
        .Fault     (Fault)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Tasks are entered and left 1 time unit after a rising edge.
    task automatic do_store(input bit b, input logic [31:0] a, input logic [31:0] d,
                            input bit exp_fault, input string tag);
        MemRead   = 1'b0;
        MemWrite  = 1'b1;
        ByteAcc   = b;
        Addr      = a;
        WriteData = d;
        @(negedge Clk);
        chk({tag, "_stall"}, {31'b0, Stall}, 32'd0);
        chk({tag, "_fault"}, {31'b0, Fault}, {31'b0, exp_fault});
        @(posedge Clk); #1;
        MemWrite = 1'b0;
    endtask

    task automatic do_load(input bit b, input logic [31:0] a, input logic [31:0] exp_d,
                           input bit exp_fault, input string tag);
        int stalls = 0;
        bit done   = 1'b0;
        MemRead  = 1'b1;
        MemWrite = 1'b0;
        ByteAcc  = b;
        Addr     = a;
        for (int c = 0; c < 40 && !done; c++) begin
            @(negedge Clk);
            if (Stall) begin
                stalls++;
                @(posedge Clk); #1;
                MemRead   = 1'b0;
                MemWrite  = 1'($urandom);
                ByteAcc   = 1'($urandom);
                Addr      = $urandom;
                WriteData = $urandom;
            end else begin
                done = 1'b1;
            end
        end
        chk({tag, "_done"},  {31'b0, done}, 32'd1);
        chk({tag, "_stall"}, stalls, 1 + W);
        chk({tag, "_data"},  ReadData, exp_d);
        chk({tag, "_fault"}, {31'b0, Fault}, {31'b0, exp_fault});
        @(posedge Clk); #1;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
    endtask

    function automatic int widx(input logic [31:0] a);
        return int'((a / 4) % DEPTH);
    endfunction

    function automatic bit m_fault(input bit b, input logic [31:0] a);
        return ALIGN && !b && (a % 4 != 0);
    endfunction

    function automatic logic [31:0] m_load(input bit b, input logic [31:0] a);
        int sh;
        sh = 8 * int'(a % 4);
        if (b) return (model[widx(a)] >> sh) & 32'hFF;
        if (m_fault(b, a)) return 32'h0;
        return model[widx(a)];
    endfunction

    task automatic m_store(input bit b, input logic [31:0] a, input logic [31:0] d);
        int sh;
        sh = 8 * int'(a % 4);
        if (b) begin
            model[widx(a)] = (model[widx(a)] & ~(32'hFF << sh)) | ((d & 32'hFF) << sh);
        end else if (!m_fault(b, a)) begin
            model[widx(a)] = d;
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] last;
        int idx [16];

        // Directed vectors: {is_load, byte, addr, wdata, expected data, expected fault}.
        vecs.push_back('{0, 0, 32'h40,   32'hDEADBEEF, 32'h0,        0});
        vecs.push_back('{1, 0, 32'h40,   32'h0,        32'hDEADBEEF, 0});
        vecs.push_back('{0, 0, 32'h40,   32'h11223344, 32'h0,        0});
        vecs.push_back('{0, 1, 32'h43,   32'hFFFFFF5A, 32'h0,        0});
        vecs.push_back('{1, 0, 32'h40,   32'h0,        32'h5A223344, 0});
        vecs.push_back('{1, 1, 32'h43,   32'h0,        32'h0000005A, 0});
        vecs.push_back('{1, 1, 32'h41,   32'h0,        32'h00000033, 0});
        vecs.push_back('{0, 0, 32'h0,    32'h00000001, 32'h0,        0});
        vecs.push_back('{1, 0, 32'h1000, 32'h0,        32'h00000001, 0});
        vecs.push_back('{1, 0, 32'h0,    32'h0,        32'h00000001, 0});
        vecs.push_back('{1, 1, 32'h1000, 32'h0,        32'h00000001, 0});
        vecs.push_back('{0, 0, 32'h42,   32'hFFFFFFFF, 32'h0,        ALIGN});
        vecs.push_back('{1, 0, 32'h40,   32'h0,
                         ALIGN ? 32'h5A223344 : 32'hFFFFFFFF, 0});
        vecs.push_back('{1, 0, 32'h42,   32'h0,
                         ALIGN ? 32'h0 : 32'hFFFFFFFF, ALIGN});

        Rst = 1'b0; MemRead = 1'b1; MemWrite = 1'b0; ByteAcc = 1'b0;
        Addr = 32'h40; WriteData = 32'h0;

        // Hold reset for 2 cycles while a load is requested.
        @(posedge Clk);
        for (int i = 0; i < 2; i++) begin
            @(negedge Clk);
            chk("rst_stall", {31'b0, Stall}, 32'd0);
            chk("rst_rdata", ReadData, 32'd0);
            chk("rst_fault", {31'b0, Fault}, 32'd0);
            @(posedge Clk);
        end
        #1;
        Rst = 1'b1; MemRead = 1'b0;

        last = 32'h0;
        foreach (vecs[i]) begin
            if (vecs[i].is_load) begin
                do_load(vecs[i].b, vecs[i].addr, vecs[i].exp_data, vecs[i].exp_fault,
                        $sformatf("vec%0d", i));
                last = vecs[i].exp_data;
            end else begin
                do_store(vecs[i].b, vecs[i].addr, vecs[i].wdata, vecs[i].exp_fault,
                         $sformatf("vec%0d", i));
            end
        end

        // After a load, ReadData holds through idle cycles and stores.
        @(negedge Clk);
        chk("hold_idle", ReadData, last);
        @(posedge Clk); #1;
        do_store(0, 32'h80, 32'hCAFEF00D, 0, "st80");
        @(negedge Clk);
        chk("hold_store", ReadData, last);
        @(posedge Clk); #1;

        // Apply reset during WAIT, which aborts the load and clears ReadData.
        MemRead = 1'b1; ByteAcc = 1'b0; Addr = 32'h80;
        @(posedge Clk); #1;
        MemRead = 1'b0;
        Rst     = 1'b0;
        @(negedge Clk);
        chk("midrst_stall", {31'b0, Stall}, 32'd0);
        @(posedge Clk); #1;
        Rst = 1'b1;
        @(negedge Clk);
        chk("midrst_stall_after", {31'b0, Stall}, 32'd0);
        chk("midrst_rdata", ReadData, 32'd0);
        chk("midrst_fault", {31'b0, Fault}, 32'd0);
        @(posedge Clk); #1;
        do_load(0, 32'h80, 32'hCAFEF00D, 0, "post_rst_ld");

        // Randomized traffic over 16 seeded words, with aliasing upper address bits.
        for (int k = 0; k < 16; k++) begin
            logic [31:0] a, d;
            idx[k] = (k * 67 + 5) % DEPTH;
            a = ($urandom << 12) | (idx[k] << 2);
            d = $urandom;
            m_store(0, a, d);
            do_store(0, a, d, 0, "rinit");
        end
        for (int n = 0; n < 150; n++) begin
            logic [31:0] a, d;
            bit b;
            a = ($urandom << 12) | (idx[$urandom_range(0, 15)] << 2) | $urandom_range(0, 3);
            b = 1'($urandom);
            if ($urandom_range(0, 1) == 0) begin
                d = $urandom;
                do_store(b, a, d, m_fault(b, a), "rst_op");
                m_store(b, a, d);
            end else begin
                do_load(b, a, m_load(b, a), m_fault(b, a), "rld_op");
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
